// File: rtl/peripheral_arbiter.sv
// peripheral_arbiter
//   Shares one peripheral_master (64-bit side) between NUM_REQ requesters.
//   One-cycle request pulses are captured into per-requester pending slots.
//   Slots are granted round-robin. The granted request's fields are held at
//   the master until it reports completion, and the response is routed back
//   to the granted requester.
//
// Ports
//   M_AXI_ACLK / M_AXI_ARESET   clock, synchronous active-high reset
//   REQ_VALID[NUM_REQ]          per-requester request pulse
//   REQ_ADDR/REQ_WDATA          packed 64-bit fields, slice i = [64*i +: 64]
//   REQ_WSTRB                   packed 8-bit strobes, slice i = [8*i +: 8]
//   REQ_WRITE/REQ_WORD          per-requester write flag / 32-bit access flag
//   REQ_READY[NUM_REQ]          one-cycle completion pulse to requester i
//   REQ_RDATA                   shared read data, valid with REQ_READY
//   REQ_OVERRUN[NUM_REQ]        sticky: request arrived while slot already pending
//   ADDR_TO_PERI_VALID          one-cycle start pulse to the master
//   ADDR_TO_PERI, DATA_TO_PERI, WSTRB, WRITE_TO_PERI, PERI_WORD_ACCESS
//                               request fields, stable from grant to completion
//   DATA_FROM_PERI_READY        completion pulse from the master
//   DATA_FROM_PERI              read data from the master
module peripheral_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic                   M_AXI_ACLK,
  input  logic                   M_AXI_ARESET,
  input  logic [NUM_REQ-1:0]     REQ_VALID,
  input  logic [NUM_REQ*64-1:0]  REQ_ADDR,
  input  logic [NUM_REQ*64-1:0]  REQ_WDATA,
  input  logic [NUM_REQ*8-1:0]   REQ_WSTRB,
  input  logic [NUM_REQ-1:0]     REQ_WRITE,
  input  logic [NUM_REQ-1:0]     REQ_WORD,
  output logic [NUM_REQ-1:0]     REQ_READY,
  output logic [63:0]            REQ_RDATA,
  output logic [NUM_REQ-1:0]     REQ_OVERRUN,
  output logic                   ADDR_TO_PERI_VALID,
  output logic [63:0]            ADDR_TO_PERI,
  output logic [63:0]            DATA_TO_PERI,
  output logic [7:0]             WSTRB,
  output logic                   WRITE_TO_PERI,
  output logic                   PERI_WORD_ACCESS,
  input  logic                   DATA_FROM_PERI_READY,
  input  logic [63:0]            DATA_FROM_PERI
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] pending;
  logic [63:0]        addr_q  [NUM_REQ];
  logic [63:0]        wdata_q [NUM_REQ];
  logic [7:0]         wstrb_q [NUM_REQ];
  logic [NUM_REQ-1:0] write_q;
  logic [NUM_REQ-1:0] word_q;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   gnt;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   idx;
  logic               pick_vld;
  logic               complete;

  assign complete = (state == WAIT) && DATA_FROM_PERI_READY;

  // Round-robin pick: scan from last+NUM_REQ down to last+1 so the closest
  // pending slot after the previous grant is the one that sticks.
  always_comb begin
    pick_vld = 1'b0;
    pick     = last;
    idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % NUM_REQ);
      if (pending[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (DATA_FROM_PERI_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) state <= IDLE;
    else              state <= state_nxt;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      pending            <= '0;
      REQ_OVERRUN        <= '0;
      REQ_READY          <= '0;
      REQ_RDATA          <= '0;
      last               <= IDX_W'(NUM_REQ - 1);
      gnt                <= '0;
      ADDR_TO_PERI_VALID <= 1'b0;
      ADDR_TO_PERI       <= '0;
      DATA_TO_PERI       <= '0;
      WSTRB              <= '0;
      WRITE_TO_PERI      <= 1'b0;
      PERI_WORD_ACCESS   <= 1'b0;
      write_q            <= '0;
      word_q             <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        wstrb_q[i] <= '0;
      end
    end else begin
      ADDR_TO_PERI_VALID <= 1'b0;
      REQ_READY          <= '0;

      // Grant: copy the winner's fields to the master; they stay put until
      // the next grant, which cannot happen before completion.
      if (state == IDLE && pick_vld) begin
        ADDR_TO_PERI       <= addr_q[pick];
        DATA_TO_PERI       <= wdata_q[pick];
        WSTRB              <= wstrb_q[pick];
        WRITE_TO_PERI      <= write_q[pick];
        PERI_WORD_ACCESS   <= word_q[pick];
        ADDR_TO_PERI_VALID <= 1'b1;
        last               <= pick;
        gnt                <= pick;
      end

      // Completion: route the response to the granted requester.
      if (complete) begin
        REQ_READY[gnt] <= 1'b1;
        REQ_RDATA      <= DATA_FROM_PERI;
      end

      // Capture: a slot completing this cycle is free again, so a request
      // arriving on the same edge is accepted and the set wins over the clear.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (REQ_VALID[i]) begin
          if (!pending[i] || (complete && gnt == IDX_W'(i))) begin
            pending[i] <= 1'b1;
            addr_q[i]  <= REQ_ADDR[64*i +: 64];
            wdata_q[i] <= REQ_WDATA[64*i +: 64];
            wstrb_q[i] <= REQ_WSTRB[8*i +: 8];
            write_q[i] <= REQ_WRITE[i];
            word_q[i]  <= REQ_WORD[i];
          end else begin
            REQ_OVERRUN[i] <= 1'b1;
          end
        end else if (complete && gnt == IDX_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_peripheral_arbiter.sv
module tb_peripheral_arbiter;
  localparam int N  = 2;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    stim_vld, echo_vld, req_valid;
  logic [N*64-1:0] req_addr, req_wdata;
  logic [N*8-1:0]  req_wstrb;
  logic [N-1:0]    req_write, req_word;
  logic [N-1:0]    req_ready, req_overrun;
  logic [63:0]     req_rdata;
  logic            a_vld;
  logic [63:0]     a_addr, a_data;
  logic [7:0]      a_wstrb;
  logic            a_write, a_word;
  logic            peri_rdy;
  logic [63:0]     peri_data;

  assign req_valid = stim_vld | echo_vld;

  always #5 clk = ~clk;

  peripheral_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .REQ_VALID(req_valid), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .REQ_WSTRB(req_wstrb), .REQ_WRITE(req_write), .REQ_WORD(req_word),
    .REQ_READY(req_ready), .REQ_RDATA(req_rdata), .REQ_OVERRUN(req_overrun),
    .ADDR_TO_PERI_VALID(a_vld), .ADDR_TO_PERI(a_addr), .DATA_TO_PERI(a_data),
    .WSTRB(a_wstrb), .WRITE_TO_PERI(a_write), .PERI_WORD_ACCESS(a_word),
    .DATA_FROM_PERI_READY(peri_rdy), .DATA_FROM_PERI(peri_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        write;
    logic        word;
  } fld_t;
  typedef struct packed {
    logic [N-1:0] mask;
    logic [63:0]  data;
  } rsp_t;

  fld_t         m_fld [N];
  logic [N-1:0] m_pend, m_ovr;
  int           m_last, m_g, m_ph;  // m_ph: 0 free, 1 start cycle, 2 waiting
  fld_t         m_cur;
  fld_t         exp_issue[$];
  rsp_t         exp_resp[$];
  logic [63:0]  glog[$];
  int           n_done = 0;

  always @(posedge clk) begin : model
    logic         compl;
    logic [N-1:0] old;
    int           j;
    rsp_t         r;
    fld_t         f;
    if (rst) begin
      m_pend = '0; m_ovr = '0; m_last = N - 1; m_g = 0; m_ph = 0; m_cur = '0;
      for (int i = 0; i < N; i++) m_fld[i] = '0;
      exp_issue.delete();
      exp_resp.delete();
    end else begin
      compl = (m_ph == 2) && peri_rdy;
      old   = m_pend;
      if (m_ph == 0) begin
        if (old != '0) begin
          for (int k = N; k >= 1; k--) begin
            j = (m_last + k) % N;
            if (old[j]) m_g = j;
          end
          m_cur  = m_fld[m_g];
          m_last = m_g;
          m_ph   = 1;
          exp_issue.push_back(m_cur);
        end
      end else if (m_ph == 1) begin
        m_ph = 2;
      end else if (compl) begin
        r.mask = N'(1) << m_g;
        r.data = peri_data;
        exp_resp.push_back(r);
        m_ph = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (!old[i] || (compl && m_g == i)) begin
            f.addr  = req_addr[64*i +: 64];
            f.wdata = req_wdata[64*i +: 64];
            f.wstrb = req_wstrb[8*i +: 8];
            f.write = req_write[i];
            f.word  = req_word[i];
            m_fld[i]  = f;
            m_pend[i] = 1'b1;
          end else begin
            m_ovr[i] = 1'b1;
          end
        end else if (compl && m_g == i) begin
          m_pend[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    fld_t f;
    rsp_t r;
    if (!rst) begin
      check("start_pulse", 64'(a_vld), 64'(m_ph == 1));
      if (a_vld) begin
        glog.push_back(a_addr);
        if (exp_issue.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected actual=%h required=none", a_addr);
        end else begin
          f = exp_issue.pop_front();
          check("issue_addr", a_addr, f.addr);
          check("issue_wdata", a_data, f.wdata);
          check("issue_ctl", 64'({a_wstrb, a_write, a_word}), 64'({f.wstrb, f.write, f.word}));
        end
      end
      if (m_ph != 0) begin
        check("hold_addr", a_addr, m_cur.addr);
        check("hold_wdata", a_data, m_cur.wdata);
        check("hold_ctl", 64'({a_wstrb, a_write, a_word}), 64'({m_cur.wstrb, m_cur.write, m_cur.word}));
      end
      if (exp_resp.size() > 0) begin
        r = exp_resp.pop_front();
        check("req_ready", 64'(req_ready), 64'(r.mask));
        check("req_rdata", req_rdata, r.data);
      end else begin
        check("req_ready_quiet", 64'(req_ready), 64'(0));
      end
      if (req_ready != '0) n_done++;
      check("overrun", 64'(req_overrun), 64'(m_ovr));
    end
  end

  // ---------------- peripheral master responder ----------------
  int          fix_delay = 0;
  logic        fix_data_en = 1'b0;
  logic [63:0] fix_data = '0;
  logic        echo_en = 1'b0;
  logic        spur_en = 1'b0;
  int          rsp_d;
  logic        rsp_abort;

  always begin : responder
    @(negedge clk);
    if (!rst && a_vld) begin
      rsp_d = (fix_delay > 0) ? fix_delay : int'($urandom_range(1, 5));
      rsp_abort = 1'b0;
      if (spur_en) begin
        peri_rdy  = 1'b1;
        peri_data = {$urandom, $urandom};
      end
      for (int k = 0; k < rsp_d; k++) begin
        @(negedge clk);
        peri_rdy = 1'b0;
        if (rst) rsp_abort = 1'b1;
      end
      if (!rsp_abort && !rst) begin
        peri_rdy  = 1'b1;
        peri_data = a_write ? 64'd0 : (fix_data_en ? fix_data : {$urandom, $urandom});
        if (echo_en) echo_vld = N'(1) << m_g;
        @(negedge clk);
        peri_rdy = 1'b0;
        echo_vld = '0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] wd,
                         input logic [7:0] s, input logic w, input logic wo);
    req_addr[64*i +: 64]  = a;
    req_wdata[64*i +: 64] = wd;
    req_wstrb[8*i +: 8]   = s;
    req_write[i]          = w;
    req_word[i]           = wo;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    stim_vld = v;
    @(negedge clk);
    stim_vld = '0;
  endtask

  task automatic wait_quiet(input string nm);
    int c = 0;
    while (!(m_ph == 0 && m_pend == '0 && !peri_rdy) && c < 300) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    if (c >= 300) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d required=<300", nm, c);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    glog.delete();
  endtask

  initial begin
    rst = 1'b1; stim_vld = '0; echo_vld = '0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0; req_write = '0; req_word = '0;
    peri_rdy = 1'b0; peri_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_rdata", req_rdata, 64'(0));
    check("rst_valid", 64'(a_vld), 64'(0));
    check("rst_addr", a_addr, 64'(0));
    check("rst_overrun", 64'(req_overrun), 64'(0));
    rst = 1'b0;

    // single read, READY three cycles after the start pulse
    fix_delay = 3; fix_data_en = 1'b1; fix_data = 64'h1234;
    set_req(0, 64'h1000_0000, 64'h0, 8'h0F, 1'b0, 1'b1);
    pulse(2'b01);
    wait_quiet("t1");
    check("t1_rdata", req_rdata, 64'h1234);
    check("t1_pulses", 64'(glog.size()), 64'(1));
    fix_data_en = 1'b0; fix_delay = 0;

    // simultaneous requests after reset: req0 first
    do_reset();
    set_req(0, 64'hA0, 64'h11, 8'hFF, 1'b0, 1'b0);
    set_req(1, 64'hB0, 64'h22, 8'hF0, 1'b1, 1'b1);
    pulse(2'b11);
    wait_quiet("t2");
    check("t2_first", glog[0], 64'hA0);
    check("t2_second", glog[1], 64'hB0);

    // both slots refilled as they complete: strict alternation
    do_reset();
    echo_en = 1'b1;
    pulse(2'b11);
    begin
      int c = 0;
      while (n_done < 4 + 2 && c < 200) begin @(negedge clk); c++; end
    end
    echo_en = 1'b0;
    wait_quiet("t3");
    check("t3_g0", glog[0], 64'hA0);
    check("t3_g1", glog[1], 64'hB0);
    check("t3_g2", glog[2], 64'hA0);
    check("t3_g3", glog[3], 64'hB0);
    check("t5_no_overrun", 64'(req_overrun), 64'(0));

    // 64-bit write held until completion
    fix_delay = 5;
    set_req(1, 64'h2000, 64'hAABBCCDD_11223344, 8'hFF, 1'b1, 1'b0);
    pulse(2'b10);
    wait_quiet("t7");
    check("t7_rdata", req_rdata, 64'h0);

    // second request to a pending slot is dropped
    glog.delete();
    set_req(1, 64'h3000, 64'h0, 8'h00, 1'b0, 1'b0);
    pulse(2'b10);
    set_req(1, 64'h4000, 64'h0, 8'h00, 1'b0, 1'b0);
    pulse(2'b10);
    wait_quiet("t4");
    check("t4_overrun", 64'(req_overrun), 64'(2'b10));
    check("t4_count", 64'(glog.size()), 64'(1));
    check("t4_addr", glog[0], 64'h3000);

    // reset while the master is busy
    set_req(0, 64'h5000, 64'h0, 8'h00, 1'b0, 1'b0);
    pulse(2'b01);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_ready", 64'(req_ready), 64'(0));
    check("t6_valid", 64'(a_vld), 64'(0));
    check("t6_addr", a_addr, 64'(0));
    check("t6_data", a_data, 64'(0));
    check("t6_ctl", 64'({a_wstrb, a_write, a_word}), 64'(0));
    check("t6_overrun", 64'(req_overrun), 64'(0));
    check("t6_rdata", req_rdata, 64'(0));
    repeat (7) @(negedge clk);
    rst = 1'b0;
    glog.delete();
    fix_delay = 0;
    set_req(0, 64'h6000, 64'h0, 8'h00, 1'b0, 1'b0);
    set_req(1, 64'h7000, 64'h0, 8'h00, 1'b0, 1'b0);
    pulse(2'b11);
    wait_quiet("t6b");
    check("t6_first", glog[0], 64'h6000);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 3) == 0);
        set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                1'($urandom), 1'($urandom));
      end
      spur_en  = ($urandom_range(0, 4) == 0);
      stim_vld = v;
      @(negedge clk);
    end
    stim_vld = '0;
    spur_en  = 1'b0;
    wait_quiet("rand");
    check("issue_q_empty", 64'(exp_issue.size()), 64'(0));
    check("resp_q_empty", 64'(exp_resp.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
